// File: rtl/ro_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ro_ctrl_pkg
// Description : Shared state encoding, default sizes and sum-width helper for
//               the ring-oscillator sample controller.
// Revision    : 1.0
// ============================================================================
package ro_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        MEASURE = 3'd2,
        LATCH   = 3'd3,
        LAUNCH  = 3'd4,
        WAIT    = 3'd5,
        OUT     = 3'd6
    } state_t;

    localparam int c_DEF_WIDTH    = 6;
    localparam int c_DEF_N        = 5;
    localparam int c_DEF_TREE_LAT = 3;
    localparam int c_DEF_CNT_W    = 16;

    function automatic int sum_width(input int width, input int n);
        return width + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ro_window_timer.sv
`default_nettype none
// ============================================================================
// Module      : ro_window_timer
// Description : Loadable down-counter with terminal-count flag; parks at zero.
// Revision    : 1.0
// ============================================================================
module ro_window_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ro_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ro_sample_ctrl
// Description : Window / latch / launch / collect sequencer for one
//               ring-oscillator channel feeding add_tree.
// Revision    : 1.0
// ============================================================================
module ro_sample_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int WIDTH    = c_DEF_WIDTH,
    parameter int N        = c_DEF_N,
    parameter int WINDOW   = 64,
    parameter int TREE_LAT = c_DEF_TREE_LAT,
    parameter int CNT_W    = c_DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [CNT_W-1:0]              num_samples,
    output logic                          ro_en,
    output logic                          cnt_clr,
    output logic                          cnt_latch,
    output logic                          add_tree_en,
    output logic                          add_tree_valid_in,
    input  logic                          add_tree_valid_out,
    input  logic [sum_width(WIDTH,N)-1:0] add_tree_result,
    output logic [sum_width(WIDTH,N)-1:0] sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          tree_err
);

    localparam int               c_SW       = sum_width(WIDTH, N);
    localparam logic [CNT_W-1:0] c_WIN_LOAD = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] c_TO_LOAD  = CNT_W'(TREE_LAT);

    state_t            r_state;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_cont;
    logic              r_stop_pend;
    logic              r_ro_en, r_cnt_clr, r_cnt_latch, r_tree_en, r_valid_in;
    logic              r_sample_valid, r_busy, r_done, r_tree_err;
    logic [c_SW-1:0]   r_sample_data;

    logic              w_tmr_load, w_tmr_dec, w_tmr_tc;
    logic [CNT_W-1:0]  w_tmr_val;
    logic              w_last, w_stop;

    // One timer serves both the counting window and the tree-result timeout.
    always_comb begin
        w_tmr_load = (r_state == CLEAR) || (r_state == LAUNCH);
        w_tmr_val  = (r_state == LAUNCH) ? c_TO_LOAD : c_WIN_LOAD;
        w_tmr_dec  = (r_state == MEASURE) || (r_state == WAIT);
        w_last     = !r_cont && (r_remaining <= CNT_W'(1));
        w_stop     = r_stop_pend || stop;
    end

    ro_window_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .dec      (w_tmr_dec),
        .tc       (w_tmr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_remaining    <= '0;
            r_cont         <= 1'b0;
            r_stop_pend    <= 1'b0;
            r_ro_en        <= 1'b0;
            r_cnt_clr      <= 1'b0;
            r_cnt_latch    <= 1'b0;
            r_tree_en      <= 1'b0;
            r_valid_in     <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_data  <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_tree_err     <= 1'b0;
        end else begin
            r_cnt_clr   <= 1'b0;
            r_cnt_latch <= 1'b0;
            r_valid_in  <= 1'b0;
            r_done      <= 1'b0;
            if ((r_state != IDLE) && stop) begin
                r_stop_pend <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_remaining <= num_samples;
                        r_cont      <= (num_samples == '0);
                        r_stop_pend <= 1'b0;
                        r_tree_err  <= 1'b0;
                        r_cnt_clr   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_tree_en   <= 1'b1;
                        r_state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_ro_en <= 1'b1;
                    r_state <= MEASURE;
                end
                MEASURE: begin
                    if (w_tmr_tc) begin
                        r_ro_en     <= 1'b0;
                        r_cnt_latch <= 1'b1;
                        r_state     <= LATCH;
                    end
                end
                LATCH: begin
                    r_valid_in <= 1'b1;
                    r_state    <= LAUNCH;
                end
                LAUNCH: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (add_tree_valid_out) begin
                        r_sample_data  <= add_tree_result;
                        r_sample_valid <= 1'b1;
                        r_state        <= OUT;
                    end else if (w_tmr_tc) begin
                        r_tree_err  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_tree_en   <= 1'b0;
                        r_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                OUT: begin
                    if (r_sample_valid && sample_ready) begin
                        r_sample_valid <= 1'b0;
                        if (!r_cont && (r_remaining != '0)) begin
                            r_remaining <= r_remaining - 1'b1;
                        end
                        if (w_last || w_stop) begin
                            r_busy      <= 1'b0;
                            r_tree_en   <= 1'b0;
                            r_done      <= 1'b1;
                            r_stop_pend <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_cnt_clr <= 1'b1;
                            r_state   <= CLEAR;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ro_en             = r_ro_en;
    assign cnt_clr           = r_cnt_clr;
    assign cnt_latch         = r_cnt_latch;
    assign add_tree_en       = r_tree_en;
    assign add_tree_valid_in = r_valid_in;
    assign sample_data       = r_sample_data;
    assign sample_valid      = r_sample_valid;
    assign busy              = r_busy;
    assign done              = r_done;
    assign tree_err          = r_tree_err;

endmodule
`default_nettype wire

// File: doc/ro_sample_ctrl.md
# ro_sample_ctrl

Sequencer for one ring-oscillator measurement channel. It opens a fixed-length counting window on the N oscillator counters, latches them, and launches the latched counts into `add_tree`. It then waits for the tree's result and hands each summed sample to the capture side over a valid/ready handshake. Repeats for a programmed number of samples, or continuously until stopped.

## Interface
- `WIDTH`, 6, per-oscillator counter width (matches `add_tree` WIDTH)
- `N`, 5, number of oscillators summed by `add_tree`
- `WINDOW`, 64, counting window length in clk cycles (≥2)
- `TREE_LAT`, 3, `add_tree` latency: `add_tree_valid_out` rises TREE_LAT cycles after `add_tree_valid_in`
- `CNT_W`, 16, width of sample-count and window-timer fields

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a run; sampled only in IDLE
- `stop`  in  1  request early end; sampled in any non-IDLE state
- `num_samples`  in  CNT_W  samples per run, captured at start; 0 = continuous
- `ro_en`  out  1  enables oscillators/counters (window open)
- `cnt_clr`  out  1  synchronous clear to oscillator counters
- `cnt_latch`  out  1  snapshot counters into `add_tree` input regs
- `add_tree_en`  out  1  drives `add_tree` `en`
- `add_tree_valid_in`  out  1  one-cycle launch pulse
- `add_tree_valid_out`  in  1  tree result valid
- `add_tree_result`  in  WIDTH+$clog2(N)  tree sum
- `sample_data`  out  WIDTH+$clog2(N)  held sum
- `sample_valid`  out  1  sample available
- `sample_ready`  in  1  consumer accepts
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse on return to IDLE
- `tree_err`  out  1  sticky: tree timeout; cleared by next accepted start

## Operation
- States: IDLE → CLEAR → MEASURE → LATCH → LAUNCH → WAIT → OUT → (CLEAR | IDLE).
- IDLE: all outputs 0. `start`=1 captures `num_samples` into `remaining`, clears `tree_err`, goes to CLEAR.
- CLEAR: `cnt_clr`=1 for one cycle.
- MEASURE: `ro_en`=1 for exactly WINDOW cycles (window timer counts 0..WINDOW-1).
- LATCH: `ro_en`=0, `cnt_latch`=1 for one cycle.
- LAUNCH: `add_tree_valid_in`=1 for one cycle.
- WAIT: `add_tree_valid_in`=0. On `add_tree_valid_out`=1, register `add_tree_result` into `sample_data` and go to OUT. If no valid within TREE_LAT+2 cycles of LAUNCH, set `tree_err` and go to IDLE with `done`.
- OUT: `sample_valid`=1; `sample_data` stable until the handshake. On `sample_valid`&&`sample_ready`, decrement `remaining` (not in continuous mode). Go to IDLE if `remaining` reaches 0 or stop is pending, else go to CLEAR.
- `add_tree_en`=1 in every state except IDLE.
- `stop`: latched as stop_pending. The current sample completes through OUT, then the block goes to IDLE. `stop` in the same cycle as `start` in IDLE is ignored.
- `start` outside IDLE is ignored.
- `remaining` never underflows; num_samples=1 gives exactly one sample.
- Reset mid-run: immediate return to IDLE and all outputs 0. `sample_data`=0, `tree_err`=0.

## Timing
- Reference point: edge 0 samples `start`=1.
- CLEAR is cycle 1. MEASURE is cycles 2..WINDOW+1. LATCH is WINDOW+2. LAUNCH is WINDOW+3.
- `sample_valid` first high in cycle WINDOW+TREE_LAT+4.
- With `sample_ready` tied 1, the sample period is WINDOW+TREE_LAT+4 cycles (CLEAR through OUT inclusive).
- `done` is asserted the cycle after the final OUT handshake, coincident with IDLE.

## Structure
- Package `ro_ctrl_pkg`:
  - `state_t` enum (IDLE, CLEAR, MEASURE, LATCH, LAUNCH, WAIT, OUT)
  - default WIDTH/N/TREE_LAT/CNT_W constants
  - sum-width function WIDTH+$clog2(N)
- Sub-module `ro_window_timer`: loadable down-counter with terminal-count flag. It is reused for the MEASURE window and the WAIT timeout.
- FSM, `remaining` counter and output register stay in `ro_sample_ctrl`.

## Test plan
- Reset: hold `rst`=0 mid-MEASURE → next cycle all outputs 0, `busy`=0; release, no activity without `start`.
- Single sample: WINDOW=4, TREE_LAT=3, num_samples=1. Tree model returns 15 → `ro_en` high cycles 2–5, `add_tree_valid_in` at cycle 7, `sample_valid` with data 15 at cycle 11, `done` at cycle 12.
- Backpressure: num_samples=2, `sample_ready`=0 for 5 cycles → `sample_data` stable and `sample_valid` held. Second CLEAR occurs only after the handshake; exactly 2 samples are delivered.
- Continuous + stop: num_samples=0, assert `stop` during the 3rd MEASURE → 3rd sample delivered, then `done`, IDLE; no 4th `cnt_clr`.
- Tree timeout: tree model never asserts valid → `tree_err`=1 at cycle LAUNCH+TREE_LAT+2, `done` pulse, IDLE. The next `start` clears `tree_err`.
- Ignored inputs: `start` pulses during a run and `start`+`stop` together in IDLE → run count and timing unchanged.
